// File: rtl/swap_sequencer.sv
// Command-driven initiator for the swapping register file: paces pairwise swaps and
// optionally reverses address ranges in place when SWAP_SEQ_REVERSE_EN is defined.
module swap_sequencer #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SWAP_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_a,
  input  logic [ADDR_WIDTH-1:0] cmd_b,
  output logic [ADDR_WIDTH-1:0] address_A,
  output logic [ADDR_WIDTH-1:0] address_B,
  output logic                  swap,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam int                   CNT_WIDTH = $clog2(SWAP_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(SWAP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(1);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [ADDR_WIDTH-1:0] lo;
  logic [ADDR_WIDTH-1:0] hi;
  logic [ADDR_WIDTH-1:0] lo_next;
  logic [ADDR_WIDTH-1:0] hi_next;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  accept;
  logic                  cmd_illegal;
  logic                  last_wait;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign last_wait = (state == WAIT) && (cnt == CNT_LAST);

`ifdef SWAP_SEQ_REVERSE_EN
  logic                  op;
  logic [ADDR_WIDTH-1:0] step_lo;
  logic [ADDR_WIDTH-1:0] step_hi;

  assign step_lo = lo + 1'b1;
  assign step_hi = hi - 1'b1;

  // Address 0 is the file's scratch slot; a reversal must name an ascending range.
  assign cmd_illegal = (cmd_a == '0) || (cmd_b == '0) || (cmd_op && (cmd_a > cmd_b));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op <= 1'b0;
    end else if (accept) begin
      op <= cmd_op;
    end
  end
`else
  // Without reversal support every op=1 command is rejected outright.
  assign cmd_illegal = (cmd_a == '0) || (cmd_b == '0) || cmd_op;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    lo_next    = lo;
    hi_next    = hi;
    case (state)
      IDLE: begin
        if (accept) begin
          lo_next = cmd_a;
          hi_next = cmd_b;
          if (cmd_illegal)         next_state = ERR;
          else if (cmd_a == cmd_b) next_state = DONE;
          else                     next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (last_wait) begin
`ifdef SWAP_SEQ_REVERSE_EN
          if (op) begin
            lo_next    = step_lo;
            hi_next    = step_hi;
            next_state = (step_lo < step_hi) ? ISSUE : DONE;
          end else begin
            next_state = DONE;
          end
`else
          next_state = DONE;
`endif
        end
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lo    <= '0;
      hi    <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      lo    <= lo_next;
      hi    <= hi_next;
      if (state == ISSUE)     cnt <= CNT_LOAD;
      else if (state == WAIT) cnt <= cnt - 1'b1;
    end
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      address_A <= '0;
      address_B <= '0;
    end else begin
      swap <= (next_state == ISSUE);
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      err  <= (next_state == ERR);
      // Addresses load only on issue, so they hold through WAIT and between commands.
      if (next_state == ISSUE) begin
        address_A <= lo_next;
        address_B <= hi_next;
      end
    end
  end

endmodule

// File: tb/tb_swap_sequencer.sv
// Self-checking bench for swap_sequencer: a cycle-schedule model derived from the
// command arithmetic, a behavioural register file, and literal pins on the model.
module tb_swap_sequencer;

  localparam int AW = 7;
  localparam int S  = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_op = 1'b0;
  logic [AW-1:0] cmd_a = '0;
  logic [AW-1:0] cmd_b = '0;
  logic          cmd_ready, swap, busy, done, err;
  logic [AW-1:0] address_A, address_B;

  int total = 0;
  int bad   = 0;

  logic          cmp_en = 1'b0;
  logic          e_swap, e_busy, e_done, e_err, e_ready;
  logic [AW-1:0] e_a, e_b;
  logic [AW-1:0] last_a = '0;
  logic [AW-1:0] last_b = '0;
  string         cur_name = "idle";
  int            cur_t = 0;
  int            mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  swap_sequencer #(.ADDR_WIDTH(AW), .SWAP_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .address_A(address_A), .address_B(address_B),
    .swap(swap), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: every cycle the model is armed, all outputs are checked.
  always @(negedge clk) begin
    if (cmp_en) begin
      check($sformatf("%s t=%0d swap", cur_name, cur_t), swap, e_swap);
      check($sformatf("%s t=%0d busy", cur_name, cur_t), busy, e_busy);
      check($sformatf("%s t=%0d done", cur_name, cur_t), done, e_done);
      check($sformatf("%s t=%0d err", cur_name, cur_t), err, e_err);
      check($sformatf("%s t=%0d ready", cur_name, cur_t), cmd_ready, e_ready);
      check($sformatf("%s t=%0d addr_A", cur_name, cur_t), address_A, e_a);
      check($sformatf("%s t=%0d addr_B", cur_name, cur_t), address_B, e_b);
    end
  end

  // Behavioural register file: a swap request exchanges the two addressed words.
  always @(negedge clk) begin
    int tmp;
    if (swap === 1'b1) begin
      tmp            = mem[address_A];
      mem[address_A] = mem[address_B];
      mem[address_B] = tmp;
    end
  end

  task automatic init_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = 100 + i;
  endtask

  // Number of swaps a command must perform; is_err flags a rejected command.
  function automatic int num_swaps(input logic op, input int a, input int b, output logic is_err);
    is_err = (a == 0) || (b == 0);
    if (op) begin
`ifdef SWAP_SEQ_REVERSE_EN
      if (a > b) is_err = 1'b1;
`else
      is_err = 1'b1;
`endif
    end
    if (is_err || a == b) return 0;
    return op ? (b - a + 1) / 2 : 1;
  endfunction

  task automatic run_cmd(input string name, input logic op, input int a, input int b,
                         input bit keep_valid, input int abort_t,
                         output int done_t, output int err_t, output int swaps);
    logic is_err;
    int   n, e_end, k;
    n        = num_swaps(op, a, b, is_err);
    e_end    = (n == 0) ? 1 : 1 + n * (S + 1);
    done_t   = -1;
    err_t    = -1;
    swaps    = 0;
    cur_name = name;
    cmd_op    = op;
    cmd_a     = AW'(a);
    cmd_b     = AW'(b);
    cmd_valid = 1'b1;
    check({name, " ready_at_k"}, cmd_ready, 1);
    @(posedge clk); #1;
    if (keep_valid) cmd_a = AW'(a + 1);
    else            cmd_valid = 1'b0;
    for (int t = 1; t <= e_end + 1; t++) begin
      cur_t   = t;
      e_swap  = (n > 0) && (t < e_end) && ((t - 1) % (S + 1) == 0);
      e_busy  = (t <= e_end);
      e_ready = (t > e_end);
      e_done  = (t == e_end) && !is_err;
      e_err   = (t == e_end) && is_err;
      if (n > 0) begin
        k      = (t < e_end) ? (t - 1) / (S + 1) : n - 1;
        e_a    = AW'(a + k);
        e_b    = op ? AW'(b - k) : AW'(b);
        last_a = e_a;
        last_b = e_b;
      end else begin
        e_a = last_a;
        e_b = last_b;
      end
      if (t == e_end) cmd_valid = 1'b0;
      if (t == abort_t) begin
        cmp_en = 1'b0;
        check($sformatf("%s pre_reset swap", name), swap, e_swap);
        check($sformatf("%s pre_reset busy", name), busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check($sformatf("%s rst swap", name), swap, 0);
        check($sformatf("%s rst busy", name), busy, 0);
        check($sformatf("%s rst done", name), done, 0);
        check($sformatf("%s rst err", name), err, 0);
        check($sformatf("%s rst ready", name), cmd_ready, 1);
        check($sformatf("%s rst addr_A", name), address_A, 0);
        check($sformatf("%s rst addr_B", name), address_B, 0);
        last_a    = '0;
        last_b    = '0;
        cmd_valid = 1'b0;
        return;
      end
      cmp_en = 1'b1;
      @(negedge clk);
      if (done === 1'b1) done_t = t;
      if (err === 1'b1)  err_t = t;
      if (swap === 1'b1) swaps++;
      @(posedge clk); #1;
    end
    cmp_en = 1'b0;
  endtask

  task automatic idle_cycles(input string name, input int cycles);
    cur_name = name;
    e_swap = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
    e_a = last_a;  e_b = last_b;
    cmp_en = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      cur_t = i;
      @(negedge clk);
      @(posedge clk); #1;
    end
    cmp_en = 1'b0;
  endtask

  initial begin
    int dt, et, sw;
    init_mem();

    #2;
    check("reset swap", swap, 0);
    check("reset busy", busy, 0);
    check("reset ready", cmd_ready, 1);
    check("reset addr_A", address_A, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles("post_reset_idle", 3);

    run_cmd("pair_5_9", 1'b0, 5, 9, 1'b0, 0, dt, et, sw);
    check("lit pair_5_9 done_cycle", dt, 5);
    check("lit pair_5_9 swaps", sw, 1);
    check("mem[5]", mem[5], 109);
    check("mem[9]", mem[9], 105);

    init_mem();
    run_cmd("rev_10_15", 1'b1, 10, 15, 1'b1, 0, dt, et, sw);
`ifdef SWAP_SEQ_REVERSE_EN
    check("lit rev_10_15 done_cycle", dt, 13);
    check("lit rev_10_15 swaps", sw, 3);
    for (int i = 10; i <= 15; i++) check($sformatf("rev_10_15 mem[%0d]", i), mem[i], 125 - i);
`else
    check("lit rev_10_15 err_cycle", et, 1);
    check("lit rev_10_15 swaps", sw, 0);
`endif

    init_mem();
    run_cmd("rev_10_14", 1'b1, 10, 14, 1'b0, 0, dt, et, sw);
`ifdef SWAP_SEQ_REVERSE_EN
    check("lit rev_10_14 done_cycle", dt, 9);
    check("lit rev_10_14 swaps", sw, 2);
    for (int i = 10; i <= 14; i++) check($sformatf("rev_10_14 mem[%0d]", i), mem[i], 124 - i);
`else
    check("lit rev_10_14 err_cycle", et, 1);
`endif
    check("rev_10_14 mem[12] untouched", mem[12], 112);

    run_cmd("pair_a0", 1'b0, 0, 4, 1'b0, 0, dt, et, sw);
    check("lit pair_a0 err_cycle", et, 1);
    check("lit pair_a0 swaps", sw, 0);
    run_cmd("rev_9_3", 1'b1, 9, 3, 1'b0, 0, dt, et, sw);
    check("lit rev_9_3 err_cycle", et, 1);
    run_cmd("pair_7_7", 1'b0, 7, 7, 1'b0, 0, dt, et, sw);
    check("lit pair_7_7 done_cycle", dt, 1);
    check("lit pair_7_7 swaps", sw, 0);
    run_cmd("pair_20_6", 1'b0, 20, 6, 1'b0, 0, dt, et, sw);
    run_cmd("pair_1_127", 1'b0, 1, 127, 1'b0, 0, dt, et, sw);
    run_cmd("rev_1_2", 1'b1, 1, 2, 1'b0, 0, dt, et, sw);
    idle_cycles("between_cmds", 2);

`ifdef SWAP_SEQ_REVERSE_EN
    run_cmd("rev_abort", 1'b1, 10, 15, 1'b0, 5, dt, et, sw);
`else
    run_cmd("pair_abort", 1'b0, 10, 15, 1'b0, 1, dt, et, sw);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles("after_abort_idle", 2);
    init_mem();
    run_cmd("pair_3_4", 1'b0, 3, 4, 1'b0, 0, dt, et, sw);
    check("lit pair_3_4 done_cycle", dt, 5);
    check("mem[3]", mem[3], 104);
    check("mem[4]", mem[4], 103);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
